// File: rtl/picorv32_wb_master_pkg.sv
// Shared definitions for the picorv32 -> Wishbone bridge: bus widths,
// FSM state encodings, default error read data and the latched request.
package picorv32_wb_master_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;

  // RV32 NOP, so a faulting fetch executes harmlessly.
  localparam logic [WB_DW-1:0] ERR_RDATA_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic [3:0]       sel;
    logic             we;
    logic             instr;
  } wb_req_t;

endpackage

// File: rtl/picorv32_wb_master_timeout.sv
// Watchdog for an outstanding Wishbone cycle: counts busy cycles and flags
// expiry on the last allowed one. Used only when WB_MASTER_TIMEOUT_EN is set.
module wb_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear)       cnt_d = '0;
    else if (i_enable) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign o_expired = i_enable && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/picorv32_wb_master.sv
// picorv32 native memory port to single-beat pipelined Wishbone master.
// Optional cycle watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module picorv32_wb_master
  import picorv32_wb_master_pkg::*;
#(
  parameter logic [WB_DW-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT,
  parameter int unsigned      TIMEOUT_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_mem_valid,
  input  logic             i_mem_instr,
  input  logic [WB_AW-1:0] i_mem_addr,
  input  logic [WB_DW-1:0] i_mem_wdata,
  input  logic [3:0]       i_mem_wstrb,
  output logic             o_mem_ready,
  output logic [WB_DW-1:0] o_mem_rdata,
  output logic [WB_AW-1:0] o_wb_addr,
  output logic [WB_DW-1:0] o_wb_data,
  output logic [3:0]       o_wb_sel,
  output logic             o_wb_we,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  input  logic             i_wb_ack,
  input  logic [WB_DW-1:0] i_wb_data,
  input  logic             i_wb_stall,
  input  logic             i_wb_err,
  output logic             o_bus_err,
  output logic [WB_AW-1:0] o_bus_err_addr,
  output logic             o_err_instr
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..255");
  end

  wb_state_e        state_q, state_d;
  wb_req_t          req_q, req_d;
  logic             cyc_q, cyc_d, stb_q, stb_d;
  logic             ready_q, ready_d, berr_q, berr_d, einstr_q, einstr_d;
  logic [WB_DW-1:0] rdata_q, rdata_d;
  logic [WB_AW-1:0] eaddr_q, eaddr_d;
  logic             timeout;
  logic             fin_ok, fin_err;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .i_clk     (i_clk),
    .i_resetn  (i_resetn),
    .i_clear   (state_q == ST_IDLE || state_q == ST_DONE),
    .i_enable  (state_q == ST_REQ || state_q == ST_WAIT),
    .o_expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    rdata_d  = rdata_q;
    eaddr_d  = eaddr_q;
    einstr_d = einstr_q;
    ready_d  = 1'b0;
    berr_d   = 1'b0;
    fin_ok   = 1'b0;
    fin_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (i_mem_valid) begin
        req_d.addr  = i_mem_addr;
        req_d.data  = i_mem_wdata;
        req_d.we    = |i_mem_wstrb;
        req_d.sel   = (|i_mem_wstrb) ? i_mem_wstrb : 4'hF;
        req_d.instr = i_mem_instr;
        cyc_d       = 1'b1;
        stb_d       = 1'b1;
        state_d     = ST_REQ;
      end
      // Responses only count once the strobe is accepted (stall low).
      ST_REQ: begin
        if (!i_wb_stall && i_wb_err)      fin_err = 1'b1;
        else if (!i_wb_stall && i_wb_ack) fin_ok  = 1'b1;
        else if (timeout)                 fin_err = 1'b1;
        else if (!i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_wb_err)      fin_err = 1'b1;
        else if (i_wb_ack) fin_ok  = 1'b1;
        else if (timeout)  fin_err = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
    if (fin_ok || fin_err) begin
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      ready_d = 1'b1;
      state_d = ST_DONE;
      rdata_d = fin_err ? ERR_RDATA : i_wb_data;
    end
    if (fin_err) begin
      berr_d   = 1'b1;
      eaddr_d  = req_q.addr;
      einstr_d = req_q.instr;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      ready_q  <= 1'b0;
      berr_q   <= 1'b0;
      einstr_q <= 1'b0;
      rdata_q  <= '0;
      eaddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      ready_q  <= ready_d;
      berr_q   <= berr_d;
      einstr_q <= einstr_d;
      rdata_q  <= rdata_d;
      eaddr_q  <= eaddr_d;
    end
  end

  assign o_wb_addr      = req_q.addr;
  assign o_wb_data      = req_q.data;
  assign o_wb_sel       = req_q.sel;
  assign o_wb_we        = req_q.we;
  assign o_wb_cyc       = cyc_q;
  assign o_wb_stb       = stb_q;
  assign o_mem_ready    = ready_q;
  assign o_mem_rdata    = rdata_q;
  assign o_bus_err      = berr_q;
  assign o_bus_err_addr = eaddr_q;
  assign o_err_instr    = einstr_q;

endmodule

// File: tb/tb_picorv32_wb_master.sv
// Directed bench for picorv32_wb_master: read/write, stall, error, ack+err,
// timeout (or lack of one) and asynchronous reset mid-cycle.
module tb_picorv32_wb_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata, wb_addr, wb_dout, bus_err_addr;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, bus_err, err_instr;
  logic        wb_ack = 1'b0, wb_stall = 1'b0, wb_err = 1'b0;
  logic [31:0] wb_din = '0;

  int n_chk = 0;
  int n_err = 0;

  picorv32_wb_master dut (
    .i_clk(clk), .i_resetn(rst_n),
    .i_mem_valid(mem_valid), .i_mem_instr(mem_instr), .i_mem_addr(mem_addr),
    .i_mem_wdata(mem_wdata), .i_mem_wstrb(mem_wstrb),
    .o_mem_ready(mem_ready), .o_mem_rdata(mem_rdata),
    .o_wb_addr(wb_addr), .o_wb_data(wb_dout), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb),
    .i_wb_ack(wb_ack), .i_wb_data(wb_din), .i_wb_stall(wb_stall), .i_wb_err(wb_err),
    .o_bus_err(bus_err), .o_bus_err_addr(bus_err_addr), .o_err_instr(err_instr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic ins);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
  endtask

  initial begin
    int cyc_cnt;
    // reset state
    tick(); tick();
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_stb", 32'(wb_stb), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_berr", 32'(bus_err), 32'd0);
    chk("rst_sel", 32'(wb_sel), 32'd0);
    chk("rst_addr", wb_addr, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_eaddr", bus_err_addr, 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // plain read, no stall: ready in the 4th cycle
    start(32'h8000_0010, 32'h0, 4'h0, 1'b0);
    tick();
    chk("rd_stb", 32'(wb_stb), 32'd1);
    chk("rd_cyc", 32'(wb_cyc), 32'd1);
    chk("rd_sel", 32'(wb_sel), 32'hF);
    chk("rd_we", 32'(wb_we), 32'd0);
    chk("rd_addr", wb_addr, 32'h8000_0010);
    tick();
    chk("rd_wait_stb", 32'(wb_stb), 32'd0);
    chk("rd_wait_cyc", 32'(wb_cyc), 32'd1);
    chk("rd_wait_rdy", 32'(mem_ready), 32'd0);
    wb_ack = 1'b1; wb_din = 32'h0000_00AB;
    tick();
    chk("rd_ready", 32'(mem_ready), 32'd1);
    chk("rd_rdata", mem_rdata, 32'h0000_00AB);
    chk("rd_done_cyc", 32'(wb_cyc), 32'd0);
    chk("rd_no_err", 32'(bus_err), 32'd0);
    wb_ack = 1'b0; mem_valid = 1'b0;
    tick();
    chk("rd_ready_pulse", 32'(mem_ready), 32'd0);

    // byte write held off by 3 stall cycles; ack while stalled is ignored
    start(32'h8000_0000, 32'h0000_002A, 4'h1, 1'b0);
    wb_stall = 1'b1;
    tick();
    mem_valid = 1'b0; mem_wdata = 32'hFFFF_FFFF; mem_addr = 32'h1234_5678;
    wb_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("wr_stb", 32'(wb_stb), 32'd1);
      chk("wr_data", wb_dout, 32'h0000_002A);
      tick();
      wb_ack = 1'b0;
    end
    chk("wr_stb4", 32'(wb_stb), 32'd1);
    chk("wr_sel", 32'(wb_sel), 32'h1);
    chk("wr_we", 32'(wb_we), 32'd1);
    chk("wr_addr", wb_addr, 32'h8000_0000);
    chk("wr_stall_rdy", 32'(mem_ready), 32'd0);
    wb_stall = 1'b0;
    tick();
    chk("wr_wait_stb", 32'(wb_stb), 32'd0);
    wb_ack = 1'b1; wb_din = 32'h0;
    tick();
    chk("wr_ready", 32'(mem_ready), 32'd1);
    wb_ack = 1'b0;
    tick();
    chk("wr_ready_once", 32'(mem_ready), 32'd0);
    chk("wr_idle_cyc", 32'(wb_cyc), 32'd0);

    // ack in the same cycle the strobe is accepted
    start(32'h8000_0020, 32'h0, 4'h0, 1'b0);
    tick();
    mem_valid = 1'b0;
    wb_ack = 1'b1; wb_din = 32'h0000_0055;
    tick();
    chk("req_ack_rdy", 32'(mem_ready), 32'd1);
    chk("req_ack_rdata", mem_rdata, 32'h0000_0055);
    wb_ack = 1'b0;
    tick();

    // unmapped address: err, then a stray ack must not complete anything
    start(32'h9000_0000, 32'h0, 4'h0, 1'b1);
    tick();
    mem_valid = 1'b0;
    tick();
    wb_err = 1'b1;
    tick();
    chk("err_rdy", 32'(mem_ready), 32'd1);
    chk("err_rdata", mem_rdata, 32'h0000_0013);
    chk("err_pulse", 32'(bus_err), 32'd1);
    chk("err_addr", bus_err_addr, 32'h9000_0000);
    chk("err_instr", 32'(err_instr), 32'd1);
    chk("err_cyc", 32'(wb_cyc), 32'd0);
    wb_err = 1'b0; wb_ack = 1'b1; wb_din = 32'hDEAD_BEEF;
    tick();
    chk("err_pulse_end", 32'(bus_err), 32'd0);
    chk("stray_ack_rdy", 32'(mem_ready), 32'd0);
    chk("stray_ack_rdata", mem_rdata, 32'h0000_0013);
    wb_ack = 1'b0;
    tick();
    chk("stray_ack_cyc", 32'(wb_cyc), 32'd0);

    // ack and err together in WAIT: error wins
    start(32'h8000_0040, 32'h0, 4'h0, 1'b0);
    tick();
    mem_valid = 1'b0;
    tick();
    wb_ack = 1'b1; wb_err = 1'b1; wb_din = 32'h0000_1234;
    tick();
    chk("both_rdata", mem_rdata, 32'h0000_0013);
    chk("both_berr", 32'(bus_err), 32'd1);
    chk("both_eaddr", bus_err_addr, 32'h8000_0040);
    chk("both_instr", 32'(err_instr), 32'd0);
    wb_ack = 1'b0; wb_err = 1'b0;
    tick();

    // silent slave
    start(32'hA000_0000, 32'h0, 4'h0, 1'b0);
    tick();
    mem_valid = 1'b0;
    cyc_cnt = 0;
`ifdef WB_MASTER_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      if (wb_cyc) cyc_cnt++;
    end
    chk("to_cyc_held", 32'(cyc_cnt), 32'd15);
    tick();
    chk("to_cyc_drop", 32'(wb_cyc), 32'd0);
    chk("to_ready", 32'(mem_ready), 32'd1);
    chk("to_berr", 32'(bus_err), 32'd1);
    chk("to_rdata", mem_rdata, 32'h0000_0013);
    chk("to_eaddr", bus_err_addr, 32'hA000_0000);
    tick();
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      if (wb_cyc) cyc_cnt++;
    end
    chk("nto_cyc_held", 32'(cyc_cnt), 32'd100);
    chk("nto_no_rdy", 32'(mem_ready), 32'd0);
    wb_ack = 1'b1; wb_din = 32'h0000_0077;
    tick();
    chk("nto_late_ack", mem_rdata, 32'h0000_0077);
    wb_ack = 1'b0;
    tick();
`endif

    // asynchronous reset while waiting for ack
    start(32'h8000_0080, 32'h0, 4'h0, 1'b0);
    tick();
    mem_valid = 1'b0;
    tick();
    chk("ar_wait_cyc", 32'(wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cyc_now", 32'(wb_cyc), 32'd0);
    chk("ar_stb_now", 32'(wb_stb), 32'd0);
    wb_ack = 1'b1; wb_din = 32'h0000_5555;
    tick();
    chk("ar_no_rdy", 32'(mem_ready), 32'd0);
    wb_ack = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("ar_idle_rdy", 32'(mem_ready), 32'd0);
    start(32'h8000_0100, 32'h0, 4'h0, 1'b0);
    tick();
    mem_valid = 1'b0;
    chk("ar_new_stb", 32'(wb_stb), 32'd1);
    tick();
    wb_ack = 1'b1; wb_din = 32'h0000_CAFE;
    tick();
    chk("ar_new_rdy", 32'(mem_ready), 32'd1);
    chk("ar_new_rdata", mem_rdata, 32'h0000_CAFE);
    wb_ack = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
